pow_exp_search: RTL and testbench
=================================

POW_EXP_SEARCH -- requirements
Module: pow_exp_search

Interface
REQ-001 Parameter BOUND_W, default 16, width of boundary operand.
REQ-002 Parameter BASE_W, default 9, width of base operand.
REQ-003 Parameter EXP_W, default 8, width of exponent result.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  request; sampled only in IDLE or DONE.
REQ-007 Port mode  input  1  0 = CEIL (smallest e with base^e >= boundary), 1 = FLOOR (largest e with base^e <= boundary).
REQ-008 Port boundary  input  BOUND_W  unsigned limit, latched on accepted start.
REQ-009 Port base  input  BASE_W  unsigned base, latched on accepted start.
REQ-010 Port busy  output  1  high in RUN.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port exponent  output  EXP_W  result; held from done until next accepted start.
REQ-013 Port err  output  1  invalid request flag, valid with done, held like exponent.
REQ-014 Port sat  output  1  exponent capped flag, valid with done, held like exponent.

Function
REQ-015 FSM states IDLE, RUN, DONE; start accepted in IDLE or DONE -> RUN, latching boundary, base, mode; prod <= 1, exp <= 0, err <= 0, sat <= 0.
REQ-016 start in RUN shall be ignored; no restart, latched operands unchanged.
REQ-017 Each RUN cycle performs one check using full-width product p = prod*base (BOUND_W+BASE_W bits, no truncation).
REQ-018 First RUN cycle: base < 2 -> err=1, exponent=0, go DONE.
REQ-019 CEIL: prod >= boundary -> go DONE with exponent=exp; else prod <= p, exp <= exp+1.
REQ-020 FLOOR: p > boundary -> go DONE with exponent=exp; else prod <= p, exp <= exp+1.
REQ-021 FLOOR with boundary = 0 -> err=1, exponent=0 on first RUN cycle; CEIL with boundary 0 or 1 -> exponent=0, no err.
REQ-022 If exp = 2^EXP_W-1 and the rule would increment it -> go DONE, exponent=2^EXP_W-1, sat=1.
REQ-023 DONE lasts one cycle with done=1, then IDLE unless start is sampled, which goes straight to RUN.
REQ-024 Latency: done high exactly N+2 rising edges after the edge sampling start, N = number of increments performed.
REQ-025 exponent, err, sat change only on entry to DONE or on accepted start (cleared to 0).

Reset
REQ-026 rst_n low shall immediately force state IDLE, busy=0, done=0, exponent=0, err=0, sat=0, prod=1, exp=0, including mid-RUN.
REQ-027 First start after rst_n deassertion shall be accepted normally with no extra wait cycle.

Configuration
REQ-028 Macro POW_EXP_SEARCH_POWER_OUT_EN defined: extra output port power (BOUND_W+BASE_W bits) = prod at DONE (base^exponent; 0 on err), reset 0, held like exponent.
REQ-029 Macro undefined: power port and its register absent; all other behaviour identical.

Structure
REQ-030 Package pow_exp_pkg holds state enum (IDLE/RUN/DONE) and mode constants MODE_CEIL=0, MODE_FLOOR=1.
REQ-031 Combinational sub-module pow_mul_cmp computes p, prod>=boundary, p>boundary; instantiated once.

Verification
REQ-032 CEIL, boundary 100, base 3 -> exponent 5, err 0, sat 0, done at edge 7 after start.
REQ-033 FLOOR, boundary 100, base 3 -> exponent 4, done at edge 6; boundary 81 both modes -> exponent 4.
REQ-034 base 1, any mode -> err 1, exponent 0, done at edge 2; FLOOR boundary 0, base 5 -> err 1.
REQ-035 EXP_W=3, CEIL, boundary 65535, base 2 -> exponent 7, sat 1.
REQ-036 rst_n low mid-RUN -> all outputs 0 asynchronously; start pulsed during RUN -> ignored, result of original operands.
REQ-037 Back-to-back: start sampled in DONE cycle -> new run begins with no IDLE cycle, busy high next cycle.

Source files
------------

// File: rtl/pow_exp_pkg.sv
// pow_exp_pkg: shared types and constants for the pow_exp_search block.
// The FSM state enum is exported so the top can expose it on a debug port
// and so surrounding logic can decode it by name.
package pow_exp_pkg;

  // Controller states: IDLE waits for a request, RUN performs one
  // multiply/compare step per cycle, DONE presents the one-cycle result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Search direction selected by the mode input.
  // CEIL  : smallest e with base^e >= boundary
  // FLOOR : largest  e with base^e <= boundary
  localparam logic MODE_CEIL  = 1'b0;
  localparam logic MODE_FLOOR = 1'b1;

endpackage : pow_exp_pkg

// File: rtl/pow_exp_search_if.sv
// pow_exp_search_if: request/result bundle for pow_exp_search.
// Optional macro POW_EXP_SEARCH_POWER_OUT_EN adds the 'power' result signal.
//
// Handshake: the requester raises start together with mode/boundary/base.
// The block samples start on a rising edge only while idle or in its DONE
// cycle; a start seen while busy is high is ignored. busy stays high for the
// whole search, then done is high for exactly one cycle. exponent/err/sat
// (and power) are valid from that done cycle and hold until the next
// accepted start, which clears them to 0.
interface pow_exp_search_if #(
  parameter int BOUND_W = 16,
  parameter int BASE_W  = 9,
  parameter int EXP_W   = 8
);

  logic               start;
  logic               mode;
  logic [BOUND_W-1:0] boundary;
  logic [BASE_W-1:0]  base;
  logic               busy;
  logic               done;
  logic [EXP_W-1:0]   exponent;
  logic               err;
  logic               sat;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
  logic [BOUND_W+BASE_W-1:0] power;
`endif

`ifdef POW_EXP_SEARCH_POWER_OUT_EN
  modport master (
    output start, mode, boundary, base,
    input  busy, done, exponent, err, sat, power
  );
  modport slave (
    input  start, mode, boundary, base,
    output busy, done, exponent, err, sat, power
  );
`else
  modport master (
    output start, mode, boundary, base,
    input  busy, done, exponent, err, sat
  );
  modport slave (
    input  start, mode, boundary, base,
    output busy, done, exponent, err, sat
  );
`endif

endinterface : pow_exp_search_if

// File: rtl/pow_mul_cmp.sv
// pow_mul_cmp: combinational step unit for the exponent search.
// Forms the next power p = prod * base and the two comparisons the
// controller needs. The multiply is carried out at a width wide enough
// for any prod/base pair, so the p > boundary test never sees a wrapped
// value; p_o itself is only ever stored when it is <= boundary (FLOOR) or
// when prod < boundary (CEIL), both of which fit in BOUND_W+BASE_W bits.
module pow_mul_cmp
  import pow_exp_pkg::*;
#(
  parameter int BOUND_W = 16,
  parameter int BASE_W  = 9
) (
  input  logic [BOUND_W+BASE_W-1:0] prod_i,
  input  logic [BASE_W-1:0]         base_i,
  input  logic [BOUND_W-1:0]        boundary_i,
  output logic [BOUND_W+BASE_W-1:0] p_o,
  output logic                      prod_ge_o,
  output logic                      p_gt_o
);

  localparam int PW = BOUND_W + BASE_W;
  localparam int WW = PW + BASE_W;

  logic [WW-1:0] p_full;
  logic [WW-1:0] boundary_wide;
  logic [PW-1:0] boundary_pw;

  // Full-precision product and zero-extended boundary operands.
  always_comb begin
    p_full        = {{BASE_W{1'b0}}, prod_i} * {{PW{1'b0}}, base_i};
    boundary_wide = {{(WW-BOUND_W){1'b0}}, boundary_i};
    boundary_pw   = {{BASE_W{1'b0}}, boundary_i};
  end

  // Outputs: truncated next power plus the CEIL and FLOOR stop tests.
  always_comb begin
    p_o       = p_full[PW-1:0];
    prod_ge_o = (prod_i >= boundary_pw);
    p_gt_o    = (p_full > boundary_wide);
  end

endmodule : pow_mul_cmp

// File: rtl/pow_exp_search.sv
// pow_exp_search: iterative search for the exponent e relating base^e to a
// boundary, one multiply/compare per clock.
// Optional macro POW_EXP_SEARCH_POWER_OUT_EN adds a 'power' result that
// carries base^exponent (0 when the request is invalid).
// state_o exposes the controller state for debug and checkers.
module pow_exp_search
  import pow_exp_pkg::*;
#(
  parameter int BOUND_W = 16,
  parameter int BASE_W  = 9,
  parameter int EXP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pow_exp_search_if.slave    bus,
  output state_e             state_o
);

  localparam int PW = BOUND_W + BASE_W;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [BOUND_W-1:0] boundary_q, boundary_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [EXP_W-1:0]   exponent_q, exponent_d;
  logic               err_q, err_d;
  logic               sat_q, sat_d;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
  logic [PW-1:0]      power_q, power_d;
`endif

  logic [PW-1:0]      p;
  logic               prod_ge;
  logic               p_gt;
  logic               stop;
  logic               invalid;

  pow_mul_cmp #(
    .BOUND_W (BOUND_W),
    .BASE_W  (BASE_W)
  ) u_mul_cmp (
    .prod_i     (prod_q),
    .base_i     (base_q),
    .boundary_i (boundary_q),
    .p_o        (p),
    .prod_ge_o  (prod_ge),
    .p_gt_o     (p_gt)
  );

  // Per-step decisions. The invalid test only matters on the first RUN
  // cycle: operands are frozen during RUN, so an invalid request always
  // terminates there and never reaches a later step.
  always_comb begin
    stop    = (mode_q == MODE_CEIL) ? prod_ge : p_gt;
    invalid = (base_q < BASE_W'(2)) ||
              ((mode_q == MODE_FLOOR) && (boundary_q == '0));
  end

  // Next-state and datapath update: accept requests, step the search,
  // and load results on entry to DONE.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    boundary_d = boundary_q;
    base_d     = base_q;
    prod_d     = prod_q;
    exp_d      = exp_q;
    exponent_d = exponent_q;
    err_d      = err_q;
    sat_d      = sat_q;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
    power_d    = power_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = RUN;
          mode_d     = bus.mode;
          boundary_d = bus.boundary;
          base_d     = bus.base;
          prod_d     = PW'(1);
          exp_d      = '0;
          exponent_d = '0;
          err_d      = 1'b0;
          sat_d      = 1'b0;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          power_d    = '0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (invalid) begin
          state_d    = DONE;
          exponent_d = '0;
          err_d      = 1'b1;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          power_d    = '0;
`endif
        end else if (stop) begin
          state_d    = DONE;
          exponent_d = exp_q;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          power_d    = prod_q;
`endif
        end else if (exp_q == EXP_MAX) begin
          // Another increment would wrap the counter: report the cap.
          state_d    = DONE;
          exponent_d = EXP_MAX;
          sat_d      = 1'b1;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          power_d    = prod_q;
`endif
        end else begin
          prod_d = p;
          exp_d  = exp_q + EXP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces an idle, cleared block
  // immediately, even in the middle of a search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_CEIL;
      boundary_q <= '0;
      base_q     <= '0;
      prod_q     <= PW'(1);
      exp_q      <= '0;
      exponent_q <= '0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
      power_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      boundary_q <= boundary_d;
      base_q     <= base_d;
      prod_q     <= prod_d;
      exp_q      <= exp_d;
      exponent_q <= exponent_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
      power_q    <= power_d;
`endif
    end
  end

  // Status and result outputs are decoded straight from registers.
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
    bus.exponent = exponent_q;
    bus.err      = err_q;
    bus.sat      = sat_q;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
    bus.power    = power_q;
`endif
    state_o      = state_q;
  end

endmodule : pow_exp_search

// File: tb/tb_pow_exp_search.sv
// tb_pow_exp_search: self-checking bench for pow_exp_search.
// Two instances share the same stimulus: the default build (EXP_W=8) and a
// narrow one (EXP_W=3) where exponent saturation shows up readily.
module tb_pow_exp_search;
  import pow_exp_pkg::*;

  localparam int BOUND_W = 16;
  localparam int BASE_W  = 9;
  localparam int PW      = BOUND_W + BASE_W;

  typedef struct {
    int     e;
    bit     err;
    bit     sat;
    longint pw;
  } res_t;

  logic   clk;
  logic   rst_n;
  state_e st8, st3;
  int     errors;
  int     checks;

  pow_exp_search_if #(.BOUND_W(BOUND_W), .BASE_W(BASE_W), .EXP_W(8)) if8 ();
  pow_exp_search_if #(.BOUND_W(BOUND_W), .BASE_W(BASE_W), .EXP_W(3)) if3 ();

  pow_exp_search #(.BOUND_W(BOUND_W), .BASE_W(BASE_W), .EXP_W(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if8),
    .state_o (st8)
  );

  pow_exp_search #(.BOUND_W(BOUND_W), .BASE_W(BASE_W), .EXP_W(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if3),
    .state_o (st3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Straight from the definition: walk powers of base until the CEIL/FLOOR
  // condition holds, then cap the answer at the largest representable
  // exponent. Latency is (increments + 2) = (e + 2) edges.
  function automatic res_t model(input bit m, input int bnd, input int bs, input int ew);
    res_t   r;
    longint pw;
    int     e;
    int     emax;
    emax  = (1 << ew) - 1;
    r.e   = 0;
    r.err = 1'b0;
    r.sat = 1'b0;
    r.pw  = 0;
    if (bs < 2 || (m && bnd == 0)) begin
      r.err = 1'b1;
      return r;
    end
    pw = 1;
    e  = 0;
    if (!m) begin
      while (pw < longint'(bnd)) begin
        pw = pw * bs;
        e++;
      end
    end else begin
      while (pw * bs <= longint'(bnd)) begin
        pw = pw * bs;
        e++;
      end
    end
    if (e > emax) begin
      r.sat = 1'b1;
      e     = emax;
    end
    r.e  = e;
    r.pw = 1;
    for (int i = 0; i < e; i++) r.pw = r.pw * bs;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic s, input logic m, input int bnd, input int bs);
    if8.start    = s;
    if3.start    = s;
    if8.mode     = m;
    if3.mode     = m;
    if8.boundary = BOUND_W'(bnd);
    if3.boundary = BOUND_W'(bnd);
    if8.base     = BASE_W'(bs);
    if3.base     = BASE_W'(bs);
  endtask

  task automatic set_start(input logic s);
    if8.start = s;
    if3.start = s;
  endtask

  // Issues one request to both instances and checks every result against
  // the model. b2b: start is raised right now (caller is inside a DONE
  // cycle) instead of at the next falling edge. glitch_at: if nonzero, a
  // start with other operands is pulsed while the search is running.
  task automatic run_and_check(input bit m, input int bnd, input int bs, input bit b2b,
                               input int glitch_at, input string tag,
                               output int lat8_o, output logic [7:0] e8_o);
    res_t        r8, r3;
    bit          got8, got3, bad8, bad3;
    int          lat8, lat3;
    logic [7:0]  e8;
    logic [2:0]  e3;
    logic        er8, s8, er3, s3;
    logic [PW-1:0] p8, p3;
    r8 = model(m, bnd, bs, 8);
    r3 = model(m, bnd, bs, 3);
    got8 = 0; got3 = 0; bad8 = 0; bad3 = 0;
    lat8 = 0; lat3 = 0; e8 = '0; e3 = '0; er8 = 0; s8 = 0; er3 = 0; s3 = 0;
    p8 = '0; p3 = '0;
    if (!b2b) @(negedge clk);
    set_in(1'b1, m, bnd, bs);
    @(posedge clk);
    #1;
    set_start(1'b0);
    // Right after the accepting edge: running, results cleared.
    checks++;
    if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.exponent !== 8'd0 ||
        if8.err !== 1'b0 || if8.sat !== 1'b0 || st8 !== RUN) begin
      errors++;
      $display("FAIL %s accept8: busy=%b done=%b exp=%0d err=%b sat=%b st=%0d want 1 0 0 0 0 RUN",
               tag, if8.busy, if8.done, if8.exponent, if8.err, if8.sat, st8);
    end
    checks++;
    if (if3.busy !== 1'b1 || if3.exponent !== 3'd0) begin
      errors++;
      $display("FAIL %s accept3: busy=%b exp=%0d want 1 0", tag, if3.busy, if3.exponent);
    end
    for (int k = 1; k <= 300 && !(got8 && got3); k++) begin
      @(posedge clk);
      #1;
      if (glitch_at != 0 && k == glitch_at) set_in(1'b1, ~m, 7, 5);
      if (glitch_at != 0 && k == glitch_at + 1) set_start(1'b0);
      // Values seen just after edge k are what edge k+1 samples.
      if (!got8) begin
        if (if8.done === 1'b1) begin
          got8 = 1; lat8 = k + 1; e8 = if8.exponent; er8 = if8.err; s8 = if8.sat;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          p8 = if8.power;
`endif
        end else if (if8.busy !== 1'b1) bad8 = 1;
      end
      if (!got3) begin
        if (if3.done === 1'b1) begin
          got3 = 1; lat3 = k + 1; e3 = if3.exponent; er3 = if3.err; s3 = if3.sat;
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
          p3 = if3.power;
`endif
        end else if (if3.busy !== 1'b1) bad3 = 1;
      end
    end
    set_start(1'b0);
    lat8_o = lat8;
    e8_o   = e8;

    checks++;
    if (!got8 || bad8) begin
      errors++;
      $display("FAIL %s timeout8/busy8: done_seen=%b busy_dropped=%b want 1 0", tag, got8, bad8);
    end else begin
      checks++;
      if (lat8 != r8.e + 2) begin
        errors++;
        $display("FAIL %s latency8: got %0d want %0d", tag, lat8, r8.e + 2);
      end
      checks++;
      if (e8 !== 8'(r8.e) || er8 !== r8.err || s8 !== r8.sat) begin
        errors++;
        $display("FAIL %s result8: exp=%0d err=%b sat=%b want %0d %b %b",
                 tag, e8, er8, s8, r8.e, r8.err, r8.sat);
      end
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
      checks++;
      if (p8 !== PW'(r8.pw)) begin
        errors++;
        $display("FAIL %s power8: got %0d want %0d", tag, p8, r8.pw);
      end
`endif
    end

    checks++;
    if (!got3 || bad3) begin
      errors++;
      $display("FAIL %s timeout3/busy3: done_seen=%b busy_dropped=%b want 1 0", tag, got3, bad3);
    end else begin
      checks++;
      if (lat3 != r3.e + 2) begin
        errors++;
        $display("FAIL %s latency3: got %0d want %0d", tag, lat3, r3.e + 2);
      end
      checks++;
      if (e3 !== 3'(r3.e) || er3 !== r3.err || s3 !== r3.sat) begin
        errors++;
        $display("FAIL %s result3: exp=%0d err=%b sat=%b want %0d %b %b",
                 tag, e3, er3, s3, r3.e, r3.err, r3.sat);
      end
`ifdef POW_EXP_SEARCH_POWER_OUT_EN
      checks++;
      if (p3 !== PW'(r3.pw)) begin
        errors++;
        $display("FAIL %s power3: got %0d want %0d", tag, p3, r3.pw);
      end
`endif
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.exponent !== 8'd0 ||
        if8.err !== 1'b0 || if8.sat !== 1'b0 || st8 !== IDLE) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b exp=%0d err=%b sat=%b st=%0d want all 0 IDLE",
               if8.busy, if8.done, if8.exponent, if8.err, if8.sat, st8);
    end
    checks++;
    if (if3.busy !== 1'b0 || if3.done !== 1'b0 || if3.exponent !== 3'd0 || st3 !== IDLE) begin
      errors++;
      $display("FAIL reset3: busy=%b done=%b exp=%0d st=%0d want 0 0 0 IDLE",
               if3.busy, if3.done, if3.exponent, st3);
    end
  endtask

  // Worked examples with hand-derived answers, independent of the model.
  task automatic test_examples;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b0, 100, 3, 1'b0, 0, "ceil100b3", lat, e);
    checks++;
    if (e !== 8'd5 || lat != 7) begin
      errors++;
      $display("FAIL ex_ceil100b3: exp=%0d lat=%0d want 5 7", e, lat);
    end
    run_and_check(1'b1, 100, 3, 1'b0, 0, "floor100b3", lat, e);
    checks++;
    if (e !== 8'd4 || lat != 6) begin
      errors++;
      $display("FAIL ex_floor100b3: exp=%0d lat=%0d want 4 6", e, lat);
    end
    run_and_check(1'b0, 81, 3, 1'b0, 0, "ceil81b3", lat, e);
    checks++;
    if (e !== 8'd4) begin
      errors++;
      $display("FAIL ex_ceil81b3: exp=%0d want 4", e);
    end
    run_and_check(1'b1, 81, 3, 1'b0, 0, "floor81b3", lat, e);
    checks++;
    if (e !== 8'd4) begin
      errors++;
      $display("FAIL ex_floor81b3: exp=%0d want 4", e);
    end
    run_and_check(1'b1, 500, 1, 1'b0, 0, "base1", lat, e);
    checks++;
    if (e !== 8'd0 || lat != 2 || if8.err !== 1'b1) begin
      errors++;
      $display("FAIL ex_base1: exp=%0d lat=%0d err=%b want 0 2 1", e, lat, if8.err);
    end
  endtask

  // Invalid requests and boundary corner values.
  task automatic test_corners;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b1, 0,     5,   1'b0, 0, "floor_bnd0", lat, e);
    run_and_check(1'b0, 0,     5,   1'b0, 0, "ceil_bnd0",  lat, e);
    run_and_check(1'b0, 1,     7,   1'b0, 0, "ceil_bnd1",  lat, e);
    run_and_check(1'b0, 50,    0,   1'b0, 0, "ceil_base0", lat, e);
    run_and_check(1'b0, 65535, 2,   1'b0, 0, "ceil_max_b2_sat3", lat, e);
    run_and_check(1'b1, 65535, 511, 1'b0, 0, "floor_max_b511", lat, e);
    run_and_check(1'b0, 65535, 511, 1'b0, 0, "ceil_max_b511", lat, e);
  endtask

  task automatic test_done_pulse;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b1, 1000, 10, 1'b0, 0, "pulse", lat, e);
    @(posedge clk);
    #1;
    checks++;
    if (if8.done !== 1'b0 || if8.busy !== 1'b0 || st8 !== IDLE || if8.exponent !== 8'd3) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b st=%0d exp=%0d want 0 0 IDLE 3",
               if8.done, if8.busy, st8, if8.exponent);
    end
  endtask

  task automatic test_ignore_start;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b0, 65535, 3, 1'b0, 3, "ignore_start", lat, e);
  endtask

  task automatic test_back_to_back;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b0, 100,  3,  1'b0, 0, "b2b_first",  lat, e);
    run_and_check(1'b1, 1000, 10, 1'b1, 0, "b2b_second", lat, e);
    run_and_check(1'b0, 9,    2,  1'b1, 0, "b2b_third",  lat, e);
  endtask

  task automatic test_async_reset;
    int         lat;
    logic [7:0] e;
    run_and_check(1'b0, 100, 3, 1'b0, 0, "pre_reset", lat, e);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if8.exponent !== 8'd0 || if8.err !== 1'b0 || if8.sat !== 1'b0 ||
        if8.done !== 1'b0 || if8.busy !== 1'b0 || st8 !== IDLE) begin
      errors++;
      $display("FAIL reset_idle: exp=%0d err=%b sat=%b done=%b busy=%b st=%0d want 0 0 0 0 0 IDLE",
               if8.exponent, if8.err, if8.sat, if8.done, if8.busy, st8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_in(1'b1, 1'b0, 65535, 2);
    @(posedge clk);
    #1;
    set_start(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: busy=%b want 1", if8.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.exponent !== 8'd0 || st8 !== IDLE ||
        if3.busy !== 1'b0 || st3 !== IDLE) begin
      errors++;
      $display("FAIL reset_midrun: busy8=%b done8=%b exp8=%0d st8=%0d busy3=%b st3=%0d want 0 0 0 IDLE 0 IDLE",
               if8.busy, if8.done, if8.exponent, st8, if3.busy, st3);
    end
    #2;
    rst_n = 1'b1;
    // First request after release must behave normally.
    run_and_check(1'b1, 1000, 10, 1'b0, 0, "post_reset", lat, e);
  endtask

  task automatic test_random;
    int         lat;
    logic [7:0] e;
    int         bnd, bs;
    bit         m;
    for (int i = 0; i < 30; i++) begin
      m   = 1'($urandom_range(0, 1));
      bnd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300))
                                        : int'($urandom_range(0, 65535));
      bs  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 511))
                                        : int'($urandom_range(0, 12));
      run_and_check(m, bnd, bs, 1'($urandom_range(0, 1)), 0, "random", lat, e);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    set_in(1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_examples();
    test_corners();
    test_done_pulse();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pow_exp_search
